spmm_row_loader: RTL and testbench
==================================

Name: spmm_row_loader

Overview:
- Upstream feeder for the sparse dot-product PE in the SPMM stage.
- Accepts one node-info word per feature row, then a stream of CSR (col_idx, value) entries.
- Packs the entries into fixed DOT_PRODUCT_SIZE vectors and issues them to the PE with a one-cycle valid pulse.
- Waits for the PE's one-cycle ready pulse before accepting the next row, so exactly one row is in flight per PE.

Parameters:
- DATA_WIDTH, 8, width of a feature value.
- DOT_PRODUCT_SIZE, 5, vector slots per row; also the maximum non-zeros per row.
- COL_IDX_WIDTH, $clog2(DOT_PRODUCT_SIZE), column index width.
- NODE_INFO_WIDTH, $clog2(DOT_PRODUCT_SIZE)+1, node-info width: [W-1:1] = nnz count, [0] = row flag (pass-through).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- info_valid_i  in  1  node-info word available
- info_i  in  NODE_INFO_WIDTH  node-info word
- info_ready_o  out  1  loader accepts node-info
- elem_valid_i  in  1  CSR entry available
- elem_col_idx_i  in  COL_IDX_WIDTH  entry column index
- elem_value_i  in  DATA_WIDTH  entry value
- elem_ready_o  out  1  loader accepts entry
- pe_valid_o  out  1  one-cycle issue pulse to the PE
- col_idx_o  out  COL_IDX_WIDTH x [0:DOT_PRODUCT_SIZE-1]  packed column indices
- value_o  out  DATA_WIDTH x [0:DOT_PRODUCT_SIZE-1]  packed values
- node_info_o  out  NODE_INFO_WIDTH  node-info for the issued row (nnz field clamped)
- pe_ready_i  in  1  PE result-done pulse
- rows_issued_o  out  16  count of rows issued, wraps at 2^16
- nnz_err_o  out  1  sticky: some row had nnz > DOT_PRODUCT_SIZE

Behaviour:
- Reset: synchronous on rst_n=0.
  - state=IDLE.
  - All outputs 0, except info_ready_o=1 (IDLE).
  - Vectors zeroed; slot counter 0; rows_issued_o=0; nnz_err_o=0.
- States: IDLE, GATHER, ISSUE, WAIT.
- IDLE:
  - info_ready_o=1; elem_ready_o=0.
  - Info handshake: latch info_i, clear all slots to 0, slot counter=0.
  - Clamp: nnz_eff = min(info_i[W-1:1], DOT_PRODUCT_SIZE). If info_i[W-1:1] > DOT_PRODUCT_SIZE, set nnz_err_o. node_info_o carries nnz_eff and the original bit 0.
  - Next state GATHER if nnz_eff>0, else ISSUE.
- GATHER:
  - elem_ready_o=1; info_ready_o=0.
  - Each elem handshake writes elem_col_idx_i/elem_value_i into slot[counter], then counter+1.
  - On the handshake where counter+1 == nnz_eff, go to ISSUE next cycle.
  - elem_valid_i low: stall indefinitely, no state change.
- ISSUE:
  - pe_valid_o=1 for exactly this one cycle; rows_issued_o+1 in this cycle.
  - Next state WAIT.
- WAIT:
  - All ready outputs 0.
  - pe_ready_i=1: next state IDLE.
  - col_idx_o/value_o/node_info_o are held stable from ISSUE until the next IDLE info handshake.
- pe_ready_i is ignored outside WAIT, including a pulse coincident with ISSUE.
- Latency:
  - Info accept to pe_valid_o = nnz_eff+1 cycles when entries arrive back-to-back.
  - nnz=0: pe_valid_o 1 cycle after the info accept.
  - pe_ready_i to next info_ready_o = 1 cycle.
- Unused slots (index ≥ nnz_eff) are 0 in both col_idx_o and value_o.
- Slots are filled in arrival order; duplicate or unordered column indices are passed through unchanged. Column-order semantics belong to the PE.
- Reset mid-row: the row is discarded, no pe_valid_o is emitted, and the block returns to the IDLE reset state.

Decomposition:
- Shared spmm package:
  - state enum type.
  - COL_IDX_WIDTH and NODE_INFO_WIDTH derivation functions.
  - nnz-field extract helper (bits [W-1:1]), identical to the PE's usage.
- No sub-module: a single FSM plus a slot register file. The counter is inline.

Test Plan:
- Reset, then info nnz=3/flag=1 with entries (0,4),(2,7),(4,1) back-to-back:
  - pe_valid_o pulses 4 cycles after the info accept.
  - col_idx_o={0,2,4,0,0}, value_o={4,7,1,0,0}, node_info_o=4'b0111.
- Same row, with a PE model asserting pe_ready_i 3 cycles after pe_valid_o:
  - info_ready_o=1 exactly 1 cycle after pe_ready_i.
  - A second info issued early is not accepted during WAIT.
- Info nnz=0:
  - pe_valid_o 1 cycle after the accept; vectors all 0; elem_ready_o never asserted.
- Info nnz=7 (DOT_PRODUCT_SIZE=5):
  - Exactly 5 entries accepted; node_info_o nnz field=5; nnz_err_o=1 and stays 1 after later good rows.
- elem_valid_i toggling 1/0 each cycle during a nnz=5 row:
  - Slots fill in order; pe_valid_o 1 cycle after the 5th handshake.
  - A pe_ready_i pulse injected in GATHER is ignored.
- rst_n=0 for one cycle during GATHER:
  - No pe_valid_o; all outputs at reset values; rows_issued_o=0; next row loads correctly.

Source files
------------

// File: rtl/spmm_row_loader_pkg.sv
// Shared SPMM types and width helpers used by the row loader and the sparse dot-product PE.
package spmm_row_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_WAIT   = 2'd3
  } spmm_state_e;

  function automatic int col_idx_width(input int dot_product_size);
    return $clog2(dot_product_size);
  endfunction

  function automatic int node_info_width(input int dot_product_size);
    return $clog2(dot_product_size) + 1;
  endfunction

  // Node-info layout: [W-1:1] = nnz count, [0] = row flag. Caller zero-extends to 32 bits.
  function automatic logic [31:0] nnz_field(input logic [31:0] info);
    return info >> 1;
  endfunction

endpackage

// File: rtl/spmm_row_loader.sv
// Packs one CSR row into a fixed-width vector for the sparse dot-product PE and holds it
// until the PE signals done; one row in flight at a time.
module spmm_row_loader
  import spmm_row_loader_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int DOT_PRODUCT_SIZE = 5,
  parameter int COL_IDX_WIDTH    = col_idx_width(DOT_PRODUCT_SIZE),
  parameter int NODE_INFO_WIDTH  = node_info_width(DOT_PRODUCT_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       info_valid_i,
  input  logic [NODE_INFO_WIDTH-1:0] info_i,
  output logic                       info_ready_o,
  input  logic                       elem_valid_i,
  input  logic [COL_IDX_WIDTH-1:0]   elem_col_idx_i,
  input  logic [DATA_WIDTH-1:0]      elem_value_i,
  output logic                       elem_ready_o,
  output logic                       pe_valid_o,
  output logic [COL_IDX_WIDTH-1:0]   col_idx_o [0:DOT_PRODUCT_SIZE-1],
  output logic [DATA_WIDTH-1:0]      value_o [0:DOT_PRODUCT_SIZE-1],
  output logic [NODE_INFO_WIDTH-1:0] node_info_o,
  input  logic                       pe_ready_i,
  output logic [15:0]                rows_issued_o,
  output logic                       nnz_err_o
);

  localparam int NNZ_W = NODE_INFO_WIDTH - 1;

  spmm_state_e      state;
  logic [NNZ_W-1:0] cnt;
  logic [NNZ_W-1:0] cnt_nxt;
  logic [NNZ_W-1:0] nnz_raw;
  logic [NNZ_W-1:0] nnz_eff;
  logic             nnz_over;

  assign nnz_raw  = NNZ_W'(nnz_field(32'(info_i)));
  assign nnz_over = int'(nnz_raw) > DOT_PRODUCT_SIZE;
  assign nnz_eff  = nnz_over ? NNZ_W'(DOT_PRODUCT_SIZE) : nnz_raw;
  assign cnt_nxt  = cnt + NNZ_W'(1);

  assign info_ready_o = (state == ST_IDLE);
  assign elem_ready_o = (state == ST_GATHER);
  assign pe_valid_o   = (state == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      node_info_o   <= '0;
      rows_issued_o <= '0;
      nnz_err_o     <= 1'b0;
      for (int i = 0; i < DOT_PRODUCT_SIZE; i++) begin
        col_idx_o[i] <= '0;
        value_o[i]   <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (info_valid_i) begin
            // Slots are cleared here so unused lanes read as zero for the PE.
            for (int i = 0; i < DOT_PRODUCT_SIZE; i++) begin
              col_idx_o[i] <= '0;
              value_o[i]   <= '0;
            end
            cnt         <= '0;
            node_info_o <= {nnz_eff, info_i[0]};
            if (nnz_over) nnz_err_o <= 1'b1;
            state <= (nnz_eff != '0) ? ST_GATHER : ST_ISSUE;
          end
        end
        ST_GATHER: begin
          if (elem_valid_i) begin
            col_idx_o[cnt] <= elem_col_idx_i;
            value_o[cnt]   <= elem_value_i;
            cnt            <= cnt_nxt;
            if (cnt_nxt == node_info_o[NODE_INFO_WIDTH-1:1]) state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rows_issued_o <= rows_issued_o + 16'd1;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pe_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmm_row_loader.sv
// Directed bench for spmm_row_loader: hand-computed vectors, latencies and flag behaviour.
module tb_spmm_row_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       info_valid_i = 1'b0;
  logic [3:0] info_i = '0;
  logic       info_ready_o;
  logic       elem_valid_i = 1'b0;
  logic [2:0] elem_col_idx_i = '0;
  logic [7:0] elem_value_i = '0;
  logic       elem_ready_o;
  logic       pe_valid_o;
  logic [2:0] col_idx_o [0:4];
  logic [7:0] value_o [0:4];
  logic [3:0] node_info_o;
  logic       pe_ready_i = 1'b0;
  logic [15:0] rows_issued_o;
  logic       nnz_err_o;

  spmm_row_loader dut (
    .clk(clk), .rst_n(rst_n),
    .info_valid_i(info_valid_i), .info_i(info_i), .info_ready_o(info_ready_o),
    .elem_valid_i(elem_valid_i), .elem_col_idx_i(elem_col_idx_i),
    .elem_value_i(elem_value_i), .elem_ready_o(elem_ready_o),
    .pe_valid_o(pe_valid_o), .col_idx_o(col_idx_o), .value_o(value_o),
    .node_info_o(node_info_o), .pe_ready_i(pe_ready_i),
    .rows_issued_o(rows_issued_o), .nnz_err_o(nnz_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [14:0] colflat;
  logic [39:0] valflat;
  always_comb begin
    colflat = {col_idx_o[0], col_idx_o[1], col_idx_o[2], col_idx_o[3], col_idx_o[4]};
    valflat = {value_o[0], value_o[1], value_o[2], value_o[3], value_o[4]};
  end

  // Edge monitor: cycle stamps of info accepts and issue pulses, handshake tallies.
  int cyc = 0, acc_cyc = 0, pv_cyc = 0;
  int pv_cnt = 0, acc_cnt = 0, er_cnt = 0, eh_cnt = 0;
  always @(posedge clk) begin
    if (pe_valid_o === 1'b1) begin pv_cnt++; pv_cyc = cyc; end
    if (info_valid_i && info_ready_o === 1'b1) begin acc_cnt++; acc_cyc = cyc; end
    if (elem_ready_o === 1'b1) er_cnt++;
    if (elem_valid_i && elem_ready_o === 1'b1) eh_cnt++;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_info(input int nnz, input logic flag);
    int n = 0;
    info_i = {3'(nnz), flag};
    info_valid_i = 1'b1;
    while (info_ready_o !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("info_accept_timeout", 64'(n), 64'(0));
    tick();
    info_valid_i = 1'b0;
  endtask

  task automatic do_elem(input logic [2:0] col, input logic [7:0] val);
    int n = 0;
    elem_col_idx_i = col;
    elem_value_i = val;
    elem_valid_i = 1'b1;
    while (elem_ready_o !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("elem_accept_timeout", 64'(n), 64'(0));
    tick();
    elem_valid_i = 1'b0;
  endtask

  task automatic wait_pe(input int pv0, input string tag);
    int n = 0;
    while (pv_cnt == pv0 && n < 50) begin tick(); n++; end
    chk(tag, 64'(pv_cnt - pv0), 64'(1));
  endtask

  task automatic release_pe();
    pe_ready_i = 1'b1;
    tick();
    pe_ready_i = 1'b0;
    chk("release_info_ready", 64'(info_ready_o), 64'(1));
  endtask

  initial begin
    int pv0, er0, eh0, acc0;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_info_ready", 64'(info_ready_o), 64'(1));
    chk("rst_elem_ready", 64'(elem_ready_o), 64'(0));
    chk("rst_pe_valid", 64'(pe_valid_o), 64'(0));
    chk("rst_rows", 64'(rows_issued_o), 64'(0));
    chk("rst_nnz_err", 64'(nnz_err_o), 64'(0));
    chk("rst_node_info", 64'(node_info_o), 64'(0));
    chk("rst_cols", 64'(colflat), 64'(0));
    chk("rst_vals", 64'(valflat), 64'(0));

    // Row 1: nnz=3 flag=1, back-to-back entries
    pv0 = pv_cnt;
    do_info(3, 1'b1);
    do_elem(3'd0, 8'd4);
    do_elem(3'd2, 8'd7);
    do_elem(3'd4, 8'd1);
    wait_pe(pv0, "r1_pe_pulse");
    chk("r1_latency", 64'(pv_cyc - acc_cyc), 64'(4));
    chk("r1_cols", 64'(colflat), 64'({3'd0, 3'd2, 3'd4, 3'd0, 3'd0}));
    chk("r1_vals", 64'(valflat), 64'({8'd4, 8'd7, 8'd1, 8'd0, 8'd0}));
    chk("r1_node_info", 64'(node_info_o), 64'(4'b0111));
    chk("r1_rows", 64'(rows_issued_o), 64'(1));
    chk("r1_pulse_one_cycle", 64'(pe_valid_o), 64'(0));

    // PE answers 3 cycles after the pulse; an early next info must wait
    acc0 = acc_cnt;
    info_i = {3'd2, 1'b0};
    info_valid_i = 1'b1;
    tick(); tick();
    chk("wait_info_ready", 64'(info_ready_o), 64'(0));
    chk("wait_no_accept", 64'(acc_cnt - acc0), 64'(0));
    pe_ready_i = 1'b1;
    tick();
    pe_ready_i = 1'b0;
    chk("pe_ready_to_info_ready", 64'(info_ready_o), 64'(1));
    pv0 = pv_cnt;
    tick();
    info_valid_i = 1'b0;
    chk("r2_accepted", 64'(acc_cnt - acc0), 64'(1));
    chk("r2_node_info", 64'(node_info_o), 64'(4'b0100));
    chk("r2_cleared", 64'(colflat), 64'(0));
    do_elem(3'd1, 8'd9);
    do_elem(3'd3, 8'd5);
    wait_pe(pv0, "r2_pe_pulse");
    chk("r2_cols", 64'(colflat), 64'({3'd1, 3'd3, 3'd0, 3'd0, 3'd0}));
    chk("r2_vals", 64'(valflat), 64'({8'd9, 8'd5, 8'd0, 8'd0, 8'd0}));
    chk("r2_rows", 64'(rows_issued_o), 64'(2));
    release_pe();

    // nnz=0 row
    pv0 = pv_cnt;
    er0 = er_cnt;
    do_info(0, 1'b0);
    chk("z_pe_valid_next", 64'(pe_valid_o), 64'(1));
    wait_pe(pv0, "z_pe_pulse");
    chk("z_latency", 64'(pv_cyc - acc_cyc), 64'(1));
    chk("z_cols", 64'(colflat), 64'(0));
    chk("z_vals", 64'(valflat), 64'(0));
    chk("z_node_info", 64'(node_info_o), 64'(0));
    chk("z_no_elem_ready", 64'(er_cnt - er0), 64'(0));
    chk("z_rows", 64'(rows_issued_o), 64'(3));
    release_pe();

    // nnz=7 clamps to 5
    pv0 = pv_cnt;
    eh0 = eh_cnt;
    do_info(7, 1'b1);
    chk("ov_node_info", 64'(node_info_o), 64'(4'b1011));
    chk("ov_nnz_err", 64'(nnz_err_o), 64'(1));
    for (int i = 0; i < 5; i++) do_elem(3'(i), 8'(i + 1));
    elem_col_idx_i = 3'd0;
    elem_value_i = 8'd99;
    elem_valid_i = 1'b1;
    wait_pe(pv0, "ov_pe_pulse");
    tick(); tick();
    elem_valid_i = 1'b0;
    chk("ov_elem_count", 64'(eh_cnt - eh0), 64'(5));
    chk("ov_cols", 64'(colflat), 64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));
    chk("ov_vals", 64'(valflat), 64'({8'd1, 8'd2, 8'd3, 8'd4, 8'd5}));
    release_pe();

    // nnz=5 with valid toggling; stray pe_ready in GATHER and ISSUE
    pv0 = pv_cnt;
    do_info(5, 1'b0);
    pe_ready_i = 1'b1;
    tick();
    pe_ready_i = 1'b0;
    chk("tg_gather_ignores_ready", 64'(elem_ready_o), 64'(1));
    for (int i = 0; i < 5; i++) begin
      elem_col_idx_i = (i == 0) ? 3'd4 : (i < 3) ? 3'd3 : 3'(i - 3);
      elem_value_i = 8'(10 * (i + 1));
      elem_valid_i = 1'b1;
      tick();
      elem_valid_i = 1'b0;
      if (i == 4) begin
        chk("tg_pe_valid_after_5th", 64'(pe_valid_o), 64'(1));
        pe_ready_i = 1'b1;
      end
      tick();
      pe_ready_i = 1'b0;
    end
    chk("tg_issue_ignores_ready", 64'(info_ready_o), 64'(0));
    chk("tg_pulses", 64'(pv_cnt - pv0), 64'(1));
    chk("tg_cols", 64'(colflat), 64'({3'd4, 3'd3, 3'd3, 3'd0, 3'd1}));
    chk("tg_vals", 64'(valflat), 64'({8'd10, 8'd20, 8'd30, 8'd40, 8'd50}));
    chk("tg_nnz_err_sticky", 64'(nnz_err_o), 64'(1));
    chk("tg_rows", 64'(rows_issued_o), 64'(5));
    release_pe();

    // Reset during GATHER
    pv0 = pv_cnt;
    do_info(3, 1'b1);
    do_elem(3'd2, 8'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_info_ready", 64'(info_ready_o), 64'(1));
    chk("mr_elem_ready", 64'(elem_ready_o), 64'(0));
    chk("mr_rows", 64'(rows_issued_o), 64'(0));
    chk("mr_nnz_err", 64'(nnz_err_o), 64'(0));
    chk("mr_node_info", 64'(node_info_o), 64'(0));
    chk("mr_cols", 64'(colflat), 64'(0));
    chk("mr_vals", 64'(valflat), 64'(0));
    tick(); tick(); tick();
    chk("mr_no_pulse", 64'(pv_cnt - pv0), 64'(0));
    do_info(2, 1'b1);
    do_elem(3'd3, 8'd11);
    do_elem(3'd1, 8'd22);
    wait_pe(pv0, "mr_pe_pulse");
    chk("mr_next_cols", 64'(colflat), 64'({3'd3, 3'd1, 3'd0, 3'd0, 3'd0}));
    chk("mr_next_vals", 64'(valflat), 64'({8'd11, 8'd22, 8'd0, 8'd0, 8'd0}));
    chk("mr_next_node_info", 64'(node_info_o), 64'(4'b0101));
    chk("mr_next_rows", 64'(rows_issued_o), 64'(1));
    release_pe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
